// File: rtl/sha256_arbiter.sv
// Two-channel front end for a shared sha256 engine: grants round-robin, paces bytes
// into the engine, and returns the digest or a timeout error to the granted channel.
module sha256_arbiter #(
  parameter int BYTE_GAP = 0,
  parameter int TIMEOUT  = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [15:0]  s_data,
  input  logic [1:0]   s_valid,
  input  logic [1:0]   s_last,
  output logic [1:0]   s_ready,
  output logic [1:0]   grant,
  output logic [1:0]   res_valid,
  output logic         res_err,
  output logic [255:0] res_hash,
  input  logic [1:0]   res_ack,
  output logic         eng_start,
  output logic [7:0]   eng_data_in,
  output logic         eng_data_valid,
  output logic         eng_data_last,
  input  logic [255:0] eng_hash,
  input  logic         eng_done
);

  localparam int GW = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t         state, state_d;
  logic           gsel, gsel_d;
  logic           last_served, last_served_d;
  logic [GW-1:0]  gap_cnt, gap_d;
  logic [TW-1:0]  to_cnt, to_d;
  logic [1:0]     grant_d, s_ready_d, res_valid_d;
  logic           res_err_d;
  logic [255:0]   res_hash_d;
  logic           eng_start_d;
  logic [7:0]     eng_data_in_d;
  logic           eng_data_valid_d, eng_data_last_d;
  logic           accept, pick, abort;
  logic [7:0]     g_byte;

  always_comb begin
    state_d          = state;
    gsel_d           = gsel;
    last_served_d    = last_served;
    gap_d            = gap_cnt;
    to_d             = to_cnt;
    grant_d          = grant;
    s_ready_d        = s_ready;
    res_valid_d      = res_valid;
    res_err_d        = res_err;
    res_hash_d       = res_hash;
    eng_start_d      = 1'b0;
    eng_data_in_d    = eng_data_in;
    eng_data_valid_d = 1'b0;
    eng_data_last_d  = 1'b0;

    g_byte = gsel ? s_data[15:8] : s_data[7:0];
    accept = s_valid[gsel] & s_ready[gsel];
    pick   = (req == 2'b11) ? ~last_served : req[1];
    abort  = (state == S_START || state == S_STREAM || state == S_WAIT) && !req[gsel];

    if (abort) begin
      state_d   = S_IDLE;
      grant_d   = '0;
      s_ready_d = '0;
      gap_d     = '0;
      to_d      = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            gsel_d  = pick;
            grant_d = pick ? 2'b10 : 2'b01;
            state_d = S_START;
          end
        end
        S_START: begin
          eng_start_d = 1'b1;
          gap_d       = '0;
          state_d     = S_STREAM;
        end
        S_STREAM: begin
          if (accept) begin
            eng_data_in_d    = g_byte;
            eng_data_valid_d = 1'b1;
            eng_data_last_d  = s_last[gsel];
            if (s_last[gsel]) begin
              gap_d     = '0;
              to_d      = '0;
              s_ready_d = '0;
              state_d   = S_WAIT;
            end else begin
              gap_d     = GW'(BYTE_GAP);
              s_ready_d = (BYTE_GAP == 0) ? grant : 2'b00;
            end
          end else if (gap_cnt != '0) begin
            // ready is registered, so it rises on the edge the counter reaches zero
            gap_d     = gap_cnt - GW'(1);
            s_ready_d = (gap_cnt == GW'(1)) ? grant : 2'b00;
          end else begin
            s_ready_d = grant;
          end
        end
        S_WAIT: begin
          if (eng_done) begin
            res_hash_d  = eng_hash;
            res_err_d   = 1'b0;
            res_valid_d = grant;
            to_d        = '0;
            state_d     = S_RESULT;
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            res_hash_d  = '0;
            res_err_d   = 1'b1;
            res_valid_d = grant;
            to_d        = '0;
            state_d     = S_RESULT;
          end else begin
            to_d = to_cnt + TW'(1);
          end
        end
        S_RESULT: begin
          if (res_ack[gsel]) begin
            res_valid_d   = '0;
            grant_d       = '0;
            last_served_d = gsel;
            state_d       = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      gsel           <= 1'b0;
      last_served    <= 1'b1;
      gap_cnt        <= '0;
      to_cnt         <= '0;
      grant          <= '0;
      s_ready        <= '0;
      res_valid      <= '0;
      res_err        <= 1'b0;
      res_hash       <= '0;
      eng_start      <= 1'b0;
      eng_data_in    <= '0;
      eng_data_valid <= 1'b0;
      eng_data_last  <= 1'b0;
    end else begin
      state          <= state_d;
      gsel           <= gsel_d;
      last_served    <= last_served_d;
      gap_cnt        <= gap_d;
      to_cnt         <= to_d;
      grant          <= grant_d;
      s_ready        <= s_ready_d;
      res_valid      <= res_valid_d;
      res_err        <= res_err_d;
      res_hash       <= res_hash_d;
      eng_start      <= eng_start_d;
      eng_data_in    <= eng_data_in_d;
      eng_data_valid <= eng_data_valid_d;
      eng_data_last  <= eng_data_last_d;
    end
  end

endmodule
